// File: rtl/clahe_hist_ram_ctrl.sv
// Sequencer for one CLAHE histogram bank in a true dual-port RAM.
// Time-multiplexes bulk clear, per-pixel read-modify-write accumulation and bin readout.
module clahe_hist_ram_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_start,
  input  logic                  acc_start,
  input  logic                  acc_stop,
  input  logic                  rd_start,
  input  logic                  pix_valid,
  input  logic [ADDR_WIDTH-1:0] pix_bin,
  output logic                  pix_ready,
  output logic                  rd_valid,
  output logic [ADDR_WIDTH-1:0] rd_bin,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  busy,
  output logic                  done,
  output logic                  ram_ena,
  output logic                  ram_wea,
  output logic [ADDR_WIDTH-1:0] ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dina,
  input  logic [DATA_WIDTH-1:0] ram_douta,
  output logic                  ram_enb,
  output logic                  ram_web,
  output logic [ADDR_WIDTH-1:0] ram_addrb,
  output logic [DATA_WIDTH-1:0] ram_dinb,
  input  logic [DATA_WIDTH-1:0] ram_doutb
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCUM,
    S_DRAIN,
    S_READOUT
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] HALF_LAST = ADDR_WIDTH'(DEPTH / 2 - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST      = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [DATA_WIDTH-1:0] CNT_MAX   = '1;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [ADDR_WIDTH-1:0] s1_bin_q, s1_bin_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [ADDR_WIDTH-1:0] s2_bin_q, s2_bin_d;
  logic [DATA_WIDTH-1:0] s2_val_q, s2_val_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [ADDR_WIDTH-1:0] rd_bin_q, rd_bin_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] base, incr;
  logic                  doutb_unused;

  assign doutb_unused = ^ram_doutb;

  // The previous write is not yet visible to a read issued in the same cycle.
  always_comb begin
    base = (s2_valid_q && (s2_bin_q == s1_bin_q)) ? s2_val_q : ram_douta;
    incr = (base == CNT_MAX) ? base : base + DATA_WIDTH'(1);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    rd_valid_d = 1'b0;
    rd_bin_d   = rd_bin_q;
    s1_valid_d = 1'b0;
    s1_bin_d   = s1_bin_q;
    s2_valid_d = s1_valid_q;
    s2_bin_d   = s1_bin_q;
    s2_val_d   = s1_valid_q ? incr : s2_val_q;
    pix_ready  = 1'b0;
    ram_ena    = 1'b0;
    ram_wea    = 1'b0;
    ram_addra  = '0;
    ram_dina   = '0;
    ram_enb    = 1'b0;
    ram_web    = 1'b0;
    ram_addrb  = '0;
    ram_dinb   = '0;

    if (s1_valid_q) begin
      ram_enb   = 1'b1;
      ram_web   = 1'b1;
      ram_addrb = s1_bin_q;
      ram_dinb  = incr;
    end

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (clr_start)      state_d = S_CLEAR;
        else if (rd_start)  state_d = S_READOUT;
        else if (acc_start) state_d = S_ACCUM;
      end
      S_CLEAR: begin
        ram_ena   = 1'b1;
        ram_wea   = 1'b1;
        ram_addra = {cnt_q[ADDR_WIDTH-2:0], 1'b0};
        ram_enb   = 1'b1;
        ram_web   = 1'b1;
        ram_addrb = {cnt_q[ADDR_WIDTH-2:0], 1'b1};
        if (cnt_q == HALF_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      S_ACCUM: begin
        pix_ready = 1'b1;
        if (pix_valid) begin
          ram_ena    = 1'b1;
          ram_addra  = pix_bin;
          s1_valid_d = 1'b1;
          s1_bin_d   = pix_bin;
        end
        if (acc_stop) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // No reads follow ACCUM, so once this cycle's stage-1 write lands the bank is final.
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      S_READOUT: begin
        ram_ena    = 1'b1;
        ram_addra  = cnt_q;
        rd_valid_d = 1'b1;
        rd_bin_d   = cnt_q;
        if (cnt_q == LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_bin_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_bin_q   <= '0;
      s2_val_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_bin_q   <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      s1_valid_q <= s1_valid_d;
      s1_bin_q   <= s1_bin_d;
      s2_valid_q <= s2_valid_d;
      s2_bin_q   <= s2_bin_d;
      s2_val_q   <= s2_val_d;
      rd_valid_q <= rd_valid_d;
      rd_bin_q   <= rd_bin_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign rd_valid = rd_valid_q;
  assign rd_bin   = rd_bin_q;
  assign rd_data  = rd_valid_q ? ram_douta : '0;

endmodule
